// File: rtl/player_timer.sv
// player_timer: one player's BCD countdown (MM:SS) for the chess clock.
//   CLK      system clock
//   CLR      asynchronous active-high reset; reloads INIT_MIN:INIT_SEC
//   CE       single-cycle time-base tick; PRESCALE ticks make one second
//   ENABLE   this player's turn enable from the switch block
//   LOAD     synchronous reload of the initial time, returns to IDLE
//   MIN_TENS/MIN_ONES/SEC_TENS/SEC_ONES  BCD digits of remaining time
//   END      registered level, set when time reaches 00:00
//   RUNNING  registered, high while the state is RUN
// Optional build macro FISCHER_INC_EN: adds INC_SEC seconds when a turn
// ends (RUN -> PAUSE), saturating at 99:59.
module player_timer #(
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0,
  parameter int PRESCALE = 1000,
  parameter int INC_SEC  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       ENABLE,
  input  logic       LOAD,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       END,
  output logic       RUNNING
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0] I_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0] I_MO = 4'(INIT_MIN % 10);
  localparam logic [3:0] I_ST = 4'(INIT_SEC / 10);
  localparam logic [3:0] I_SO = 4'(INIT_SEC % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    mt, mo, st, so;
  logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
  logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
  logic          end_q, end_nx, run_q;
  logic          is_zero, dec_zero;

  assign MIN_TENS = mt;
  assign MIN_ONES = mo;
  assign SEC_TENS = st;
  assign SEC_ONES = so;
  assign END      = end_q;
  assign RUNNING  = run_q;

  assign is_zero  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
  // 00:01 is the only value whose decrement lands on 00:00
  assign dec_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

  // One-second BCD decrement with borrow ripple; only used when not zero
  always_comb begin
    mt_dec = mt;
    mo_dec = mo;
    st_dec = st;
    so_dec = so;
    if (so != 4'd0) so_dec = so - 4'd1;
    else begin
      so_dec = 4'd9;
      if (st != 4'd0) st_dec = st - 4'd1;
      else begin
        st_dec = 4'd5;
        if (mo != 4'd0) mo_dec = mo - 4'd1;
        else begin
          mo_dec = 4'd9;
          mt_dec = mt - 4'd1;
        end
      end
    end
  end

`ifdef FISCHER_INC_EN
  logic [3:0] mt_inc, mo_inc, st_inc, so_inc;
  logic [7:0] s_sum, m_sum;
  // Increment done in binary then split back into BCD; operands are tiny
  always_comb begin
    s_sum = 8'(st) * 8'd10 + 8'(so) + 8'(INC_SEC);
    m_sum = 8'(mt) * 8'd10 + 8'(mo);
    if (s_sum >= 8'd60) begin
      s_sum = s_sum - 8'd60;
      m_sum = m_sum + 8'd1;
    end
    if (m_sum > 8'd99) begin
      m_sum = 8'd99;
      s_sum = 8'd59;
    end
    mt_inc = 4'(m_sum / 8'd10);
    mo_inc = 4'(m_sum % 8'd10);
    st_inc = 4'(s_sum / 8'd10);
    so_inc = 4'(s_sum % 8'd10);
  end
`endif

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    end_nx   = end_q;
    mt_nx    = mt;
    mo_nx    = mo;
    st_nx    = st;
    so_nx    = so;
    case (state)
      IDLE: begin
        // zero initial time expires immediately, regardless of ENABLE
        if (is_zero) begin
          state_nx = EXPIRED;
          end_nx   = 1'b1;
        end else if (ENABLE) state_nx = RUN;
      end
      RUN: begin
        if (!ENABLE) begin
          state_nx = PAUSE;
`ifdef FISCHER_INC_EN
          mt_nx = mt_inc;
          mo_nx = mo_inc;
          st_nx = st_inc;
          so_nx = so_inc;
`endif
        end else if (CE) begin
          if (presc == P_LAST) begin
            presc_nx = '0;
            mt_nx = mt_dec;
            mo_nx = mo_dec;
            st_nx = st_dec;
            so_nx = so_dec;
            if (dec_zero) begin
              state_nx = EXPIRED;
              end_nx   = 1'b1;
            end
          end else presc_nx = presc + PW'(1);
        end
      end
      PAUSE:   if (ENABLE) state_nx = RUN;
      default: ;
    endcase
    if (LOAD) begin
      state_nx = IDLE;
      presc_nx = '0;
      end_nx   = 1'b0;
      mt_nx    = I_MT;
      mo_nx    = I_MO;
      st_nx    = I_ST;
      so_nx    = I_SO;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      presc <= '0;
      end_q <= 1'b0;
      run_q <= 1'b0;
      mt    <= I_MT;
      mo    <= I_MO;
      st    <= I_ST;
      so    <= I_SO;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      end_q <= end_nx;
      run_q <= (state_nx == RUN);
      mt    <= mt_nx;
      mo    <= mo_nx;
      st    <= st_nx;
      so    <= so_nx;
    end
  end
endmodule

// File: tb/tb_player_timer.sv
// Directed bench: six timers (PRESCALE=4) with different initial times
// share CLK/CLR/CE/LOAD and have individual ENABLEs.
module tb_player_timer;
  localparam int N = 6;
  localparam int IM [N] = '{0, 1, 10, 0, 0, 99};
  localparam int IS [N] = '{3, 0, 0, 0, 58, 58};

  logic CLK = 1'b0;
  logic CLR, CE, LOAD;
  logic [N-1:0]       en;
  logic [N-1:0][15:0] dg;
  logic [N-1:0]       ed, rn;
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < N; i++) begin : g_dut
    player_timer #(.INIT_MIN(IM[i]), .INIT_SEC(IS[i]), .PRESCALE(4), .INC_SEC(2)) u_dut (
      .CLK(CLK), .CLR(CLR), .CE(CE), .ENABLE(en[i]), .LOAD(LOAD),
      .MIN_TENS(dg[i][15:12]), .MIN_ONES(dg[i][11:8]),
      .SEC_TENS(dg[i][7:4]), .SEC_ONES(dg[i][3:0]),
      .END(ed[i]), .RUNNING(rn[i])
    );
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b0; LOAD = 1'b0; en = '0;
    #3;
    chk("rst_u0_digits", dg[0], 16'h0003);
    chk("rst_u0_end", 16'(ed[0]), 16'd0);
    chk("rst_u0_run", 16'(rn[0]), 16'd0);
    chk("rst_u3_end", 16'(ed[3]), 16'd0);
    chk("rst_u2_digits", dg[2], 16'h1000);
    @(posedge CLK); #1;
    CLR = 1'b0;
    step(1);
    chk("zero_init_end", 16'(ed[3]), 16'd1);
    chk("zero_init_run", 16'(rn[3]), 16'd0);
    chk("idle_hold", dg[0], 16'h0003);

    en = 6'b001111;
    step(1);
    chk("idle_to_run", 16'(rn[0]), 16'd1);
    chk("run_no_ce", dg[0], 16'h0003);
    CE = 1'b1;
    step(4);
    chk("u0_4ce", dg[0], 16'h0002);
    chk("u1_min_borrow", dg[1], 16'h0059);
    chk("u2_tens_borrow", dg[2], 16'h0959);
    chk("u3_expired_ignores_en", dg[3], 16'h0000);
    chk("u3_end_hold", 16'(ed[3]), 16'd1);
    step(3);
    chk("u0_7ce", dg[0], 16'h0002);
    step(1);
    chk("u0_8ce", dg[0], 16'h0001);
    chk("u0_end_not_yet", 16'(ed[0]), 16'd0);
    step(4);
    chk("u0_12ce", dg[0], 16'h0000);
    chk("u0_end", 16'(ed[0]), 16'd1);
    chk("u0_run_off", 16'(rn[0]), 16'd0);
    chk("u1_12ce", dg[1], 16'h0057);
    step(2);
    chk("u0_no_wrap", dg[0], 16'h0000);
    chk("u0_end_held", 16'(ed[0]), 16'd1);
    CE = 1'b0; en = '0;
    step(1);

    // prescaler held across a pause
    en = 6'b110000;
    step(1);
    CE = 1'b1;
    step(2);
    en = '0;
    step(1);
`ifdef FISCHER_INC_EN
    chk("fischer_carry", dg[4], 16'h0100);
    chk("fischer_sat", dg[5], 16'h9959);
`else
    chk("pause_no_inc", dg[4], 16'h0058);
    chk("pause_no_inc99", dg[5], 16'h9958);
`endif
    chk("pause_run_off", 16'(rn[4]), 16'd0);
    step(9);
`ifdef FISCHER_INC_EN
    chk("pause_hold", dg[4], 16'h0100);
`else
    chk("pause_hold", dg[4], 16'h0058);
`endif
    CE = 1'b0; en = 6'b110000;
    step(1);
    chk("pause_to_run", 16'(rn[4]), 16'd1);
    CE = 1'b1;
    step(1);
`ifdef FISCHER_INC_EN
    chk("resume_3rd", dg[4], 16'h0100);
    step(1);
    chk("resume_wrap", dg[4], 16'h0059);
    chk("resume_wrap99", dg[5], 16'h9958);
`else
    chk("resume_3rd", dg[4], 16'h0058);
    step(1);
    chk("resume_wrap", dg[4], 16'h0057);
    chk("resume_wrap99", dg[5], 16'h9957);
`endif
    CE = 1'b0; en = '0;

    // LOAD from EXPIRED
    LOAD = 1'b1;
    step(1);
    chk("load_digits", dg[0], 16'h0003);
    chk("load_end", 16'(ed[0]), 16'd0);
    chk("load_run", 16'(rn[0]), 16'd0);
    chk("load_zero_end", 16'(ed[3]), 16'd0);
    chk("load_u4", dg[4], 16'h0058);
    LOAD = 1'b0;
    step(1);
    chk("load_zero_reexpire", 16'(ed[3]), 16'd1);
    chk("load_idle_hold", dg[0], 16'h0003);

    // async CLR mid-count, mid-cycle
    en = 6'b000001; CE = 1'b1;
    step(5);
    chk("precl_digits", dg[0], 16'h0002);
    #2 CLR = 1'b1;
    #1;
    chk("aclr_digits", dg[0], 16'h0003);
    chk("aclr_run", 16'(rn[0]), 16'd0);
    chk("aclr_end", 16'(ed[3]), 16'd0);
    CLR = 1'b0; CE = 1'b0; en = '0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
